// File: rtl/viola_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | viola_pkg                                                        |
// | Opcode encodings and helpers shared by the RS and load-store buf |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package viola_pkg;

  localparam logic [4:0] ADD   = 5'b00000;
  localparam logic [4:0] SUB   = 5'b00001;
  localparam logic [4:0] SLL   = 5'b00010;
  localparam logic [4:0] SLT   = 5'b00011;
  localparam logic [4:0] SLTU  = 5'b00100;
  localparam logic [4:0] XOR   = 5'b00101;
  localparam logic [4:0] SRL   = 5'b00110;
  localparam logic [4:0] SRA   = 5'b00111;
  localparam logic [4:0] OR    = 5'b01000;
  localparam logic [4:0] AND   = 5'b01001;
  localparam logic [4:0] ADDI  = 5'b01010;
  localparam logic [4:0] SLTI  = 5'b01011;
  localparam logic [4:0] XORI  = 5'b01100;
  localparam logic [4:0] ORI   = 5'b01101;
  localparam logic [4:0] ANDI  = 5'b01110;
  localparam logic [4:0] SLLI  = 5'b01111;
  localparam logic [4:0] SRLI  = 5'b10000;
  localparam logic [4:0] SRAI  = 5'b10001;
  localparam logic [4:0] LB    = 5'b10010;
  localparam logic [4:0] LH    = 5'b10011;
  localparam logic [4:0] LW    = 5'b10100;
  localparam logic [4:0] LBU   = 5'b10101;
  localparam logic [4:0] LHU   = 5'b10110;
  localparam logic [4:0] SB    = 5'b10111;
  localparam logic [4:0] SH    = 5'b11000;
  localparam logic [4:0] SW    = 5'b11001;
  localparam logic [4:0] BEQ   = 5'b11010;
  localparam logic [4:0] BNE   = 5'b11011;
  localparam logic [4:0] LUI   = 5'b11100;
  localparam logic [4:0] AUIPC = 5'b11101;
  localparam logic [4:0] JAL_C = 5'b11110;

  localparam logic [4:0] OP_NONE  = 5'b11111;
  localparam int         TAG_NONE = 0;

  // Loads and stores live in one contiguous block of the encoding.
  function automatic logic is_mem_op(input logic [4:0] op);
    return (op >= LB) && (op <= SW);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rs_pick_lowest.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rs_pick_lowest                                                   |
// | Priority encoder: index of the lowest set request bit            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rs_pick_lowest #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_vld
);

  always_comb begin
    o_idx = '0;
    // Scan high to low so the lowest set bit is written last.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = IDX_W'(i);
    end
  end

  assign o_vld = |i_req;

endmodule
`default_nettype wire

// File: rtl/reservation_station.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reservation_station                                              |
// | Holds ALU ops until operands arrive, dispatches one per cycle    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module reservation_station
  import viola_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 3,
  parameter int OP_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  op_in,
  input  logic [31:0]      value1_in,
  input  logic [31:0]      value2_in,
  input  logic [TAG_W-1:0] query1_in,
  input  logic [TAG_W-1:0] query2_in,
  input  logic [TAG_W-1:0] target_in,
  input  logic [TAG_W-1:0] alu_num,
  input  logic [31:0]      alu_value,
  input  logic [TAG_W-1:0] mem_num,
  input  logic [31:0]      mem_value,
  output logic             rs_full,
  output logic [OP_W-1:0]  alu_op,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [TAG_W-1:0] alu_dest
);

  localparam int              c_IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              c_CNT_W    = $clog2(DEPTH + 1);
  localparam logic [OP_W-1:0] c_OP_NONE  = '1;
  localparam logic [TAG_W-1:0] c_TAG_NONE = TAG_W'(TAG_NONE);

  logic [DEPTH-1:0] r_busy;
  logic [OP_W-1:0]  r_op   [DEPTH];
  logic [31:0]      r_v1   [DEPTH];
  logic [31:0]      r_v2   [DEPTH];
  logic [TAG_W-1:0] r_q1   [DEPTH];
  logic [TAG_W-1:0] r_q2   [DEPTH];
  logic [TAG_W-1:0] r_dest [DEPTH];

  logic [DEPTH-1:0]   w_ready;
  logic [DEPTH-1:0]   w_disp_mask;
  logic [DEPTH-1:0]   w_free;
  logic [DEPTH-1:0]   w_alloc_mask;
  logic [DEPTH-1:0]   w_busy_next;
  logic [c_IDX_W-1:0] w_disp_idx;
  logic [c_IDX_W-1:0] w_alloc_idx;
  logic               w_disp_vld;
  logic               w_free_vld;
  logic               w_accept;
  logic [31:0]        w_bv1;
  logic [31:0]        w_bv2;
  logic [TAG_W-1:0]   w_bq1;
  logic [TAG_W-1:0]   w_bq2;
  logic [c_CNT_W-1:0] w_free_cnt;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ready
    assign w_ready[i] = r_busy[i] && (r_q1[i] == c_TAG_NONE) && (r_q2[i] == c_TAG_NONE);
  end

  rs_pick_lowest #(.N(DEPTH), .IDX_W(c_IDX_W)) u_pick_ready (
    .i_req (w_ready),
    .o_idx (w_disp_idx),
    .o_vld (w_disp_vld)
  );

  // A slot being dispatched this edge is already free for allocation.
  assign w_disp_mask = DEPTH'(w_disp_vld) << w_disp_idx;
  assign w_free      = ~r_busy | w_disp_mask;

  rs_pick_lowest #(.N(DEPTH), .IDX_W(c_IDX_W)) u_pick_free (
    .i_req (w_free),
    .o_idx (w_alloc_idx),
    .o_vld (w_free_vld)
  );

  assign w_accept     = (op_in != c_OP_NONE) && !is_mem_op(5'(op_in)) && w_free_vld;
  assign w_alloc_mask = DEPTH'(w_accept) << w_alloc_idx;
  assign w_busy_next  = (r_busy & ~w_disp_mask) | w_alloc_mask;

  always_comb begin
    w_bv1 = value1_in;
    w_bq1 = query1_in;
    if (query1_in != c_TAG_NONE && query1_in == alu_num) begin
      w_bv1 = alu_value;
      w_bq1 = c_TAG_NONE;
    end else if (query1_in != c_TAG_NONE && query1_in == mem_num) begin
      w_bv1 = mem_value;
      w_bq1 = c_TAG_NONE;
    end
    w_bv2 = value2_in;
    w_bq2 = query2_in;
    if (query2_in != c_TAG_NONE && query2_in == alu_num) begin
      w_bv2 = alu_value;
      w_bq2 = c_TAG_NONE;
    end else if (query2_in != c_TAG_NONE && query2_in == mem_num) begin
      w_bv2 = mem_value;
      w_bq2 = c_TAG_NONE;
    end
  end

  always_comb begin
    w_free_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_busy_next[i]) w_free_cnt = w_free_cnt + c_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= '0;
      rs_full  <= 1'b0;
      alu_op   <= c_OP_NONE;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_dest <= c_TAG_NONE;
    end else begin
      r_busy  <= w_busy_next;
      rs_full <= (w_free_cnt <= c_CNT_W'(1));
      if (w_disp_vld) begin
        alu_op   <= r_op[w_disp_idx];
        alu_a    <= r_v1[w_disp_idx];
        alu_b    <= r_v2[w_disp_idx];
        alu_dest <= r_dest[w_disp_idx];
      end else begin
        alu_op   <= c_OP_NONE;
        alu_dest <= c_TAG_NONE;
      end
    end
  end

  // Entry payload needs no reset: it is only observed through r_busy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    always_ff @(posedge clk) begin
      if (r_busy[i] && r_q1[i] != c_TAG_NONE) begin
        if (r_q1[i] == alu_num) begin
          r_v1[i] <= alu_value;
          r_q1[i] <= c_TAG_NONE;
        end else if (r_q1[i] == mem_num) begin
          r_v1[i] <= mem_value;
          r_q1[i] <= c_TAG_NONE;
        end
      end
      if (r_busy[i] && r_q2[i] != c_TAG_NONE) begin
        if (r_q2[i] == alu_num) begin
          r_v2[i] <= alu_value;
          r_q2[i] <= c_TAG_NONE;
        end else if (r_q2[i] == mem_num) begin
          r_v2[i] <= mem_value;
          r_q2[i] <= c_TAG_NONE;
        end
      end
      if (w_alloc_mask[i]) begin
        r_op[i]   <= op_in;
        r_v1[i]   <= w_bv1;
        r_q1[i]   <= w_bq1;
        r_v2[i]   <= w_bv2;
        r_q2[i]   <= w_bq2;
        r_dest[i] <= target_in;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/reservation_station.md
# reservation_station

Holds decoded operations issued by the reorder buffer until both source operands are available, then dispatches one ready operation per cycle to the ALU. Sits between the reorder buffer (upstream: `op_out`, `value*_out`, `query*_out`, `target`) and the ALU (downstream). It snoops the ALU and memory result broadcasts (`alu_num`/`alu_value`, `mem_num`/`mem_value`) to wake up waiting operands. It drives `rs_full` back to the reorder buffer.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries, at least 2.
- `TAG_W`, default 3: ROB tag width; tag 0 means "no tag / value present".
- `OP_W`, default 5: opcode width; all-ones (5'b11111) means "no operation".

Ports:
- `clk` input 1: single clock, all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `op_in` input OP_W: issued opcode; 5'b11111 means no issue.
- `value1_in`, `value2_in` input 32 each: operand values, meaningful when the matching query is 0.
- `query1_in`, `query2_in` input TAG_W each: ROB tag still to be produced; 0 means the value is already valid.
- `target_in` input TAG_W: ROB entry that receives the result.
- `alu_num` input TAG_W, `alu_value` input 32: ALU broadcast; `alu_num` 0 means idle.
- `mem_num` input TAG_W, `mem_value` input 32: memory broadcast; `mem_num` 0 means idle.
- `rs_full` output 1: stop issuing.
- `alu_op` output OP_W: dispatched opcode; 5'b11111 means none.
- `alu_a`, `alu_b` output 32 each: dispatched operands.
- `alu_dest` output TAG_W: dispatched ROB tag; 0 when no dispatch.

## Operation
- Entry fields: `busy`, `op`, `v1`, `q1`, `v2`, `q2`, `dest`.
- Accepted ops: every op except loads and stores (LB..SW, 5'b10010–5'b11001) and 5'b11111. Load and store ops are ignored here; the load-store buffer owns them.
- Allocation: an accepted op is written into the lowest-index free entry.
- Same-cycle bypass at allocation: if `query1_in` is nonzero and equals a nonzero `alu_num`, store `v1=alu_value`, `q1=0`. Otherwise, if it equals a nonzero `mem_num`, use `mem_value`. The same rule applies to operand 2. ALU has priority if both tags match, which is illegal anyway.
- Wakeup: every busy entry with `qX` nonzero and `qX == alu_num` (or `mem_num`) captures the value and clears `qX`. Both operands of one entry may wake in the same cycle.
- Ready means `busy && q1==0 && q2==0`, evaluated on registered state.
  - An entry woken or allocated in cycle N is first ready in cycle N+1.
- Dispatch: each cycle, pick the lowest-index ready entry.
  - Register `alu_op/alu_a/alu_b/alu_dest` from it and clear `busy` in the same edge.
  - With no ready entry, `alu_op`=5'b11111 and `alu_dest`=0. `alu_a/alu_b` hold their previous values.
- A dispatched slot may be reallocated on the same edge; allocation sees the slot as free after dispatch.
- `rs_full` is registered: 1 when the number of free entries after this edge's allocate and dispatch is ≤1. This leaves one slot of margin for the reorder buffer's negedge issue latency.
- Issue while no entry is free: the op is dropped and state is unchanged. The bench asserts this never happens.

## Timing
- Reset (synchronous, on posedge with `rst`=1):
  - All `busy`=0.
  - `alu_op`=5'b11111, `alu_a`=0, `alu_b`=0, `alu_dest`=0, `rs_full`=0.
  - An issue or broadcast arriving in the reset cycle is discarded.
- Latency:
  - Issue with both operands ready at edge N produces a dispatch on outputs after edge N+1.
  - A broadcast at edge N that wakes the last operand produces a dispatch after edge N+1.
- Throughput: one issue and one dispatch per cycle, sustained while free entries ≥2.
- A broadcast whose tag matches no entry has no effect.
- Tag 0 on a broadcast never matches, even if an entry's `q` is 0.

## Structure
- Shared package `viola_pkg`:
  - Opcode localparams (ADD..JAL_C), `OP_NONE`=5'b11111, `TAG_NONE`=0.
  - Function `is_mem_op(op)`, shared with the load-store buffer.
- Sub-module `rs_pick_lowest`: parameterised priority encoder returning index and valid. Instantiated twice, once for the free-slot search and once for the ready-entry search.

## Test plan
- Issue ADD with q1=q2=0, v1=5, v2=7, target=3.
  - After edge 2: `alu_op`=ADD, `alu_a`=5, `alu_b`=7, `alu_dest`=3.
  - After edge 3: `alu_op`=5'b11111.
- Issue SUB with q1=2 and q2=0 (v2=1); two cycles later broadcast `alu_num`=2, `alu_value`=10.
  - Dispatch on the following cycle: `alu_a`=10, `alu_b`=1.
- Issue with `query1_in`=4 in the same cycle as `mem_num`=4, `mem_value`=0x55.
  - Entry is ready next cycle; dispatch shows `alu_a`=0x55.
- Issue 3 dependent ops into DEPTH=4.
  - `rs_full`=1 after the 3rd issue edge.
  - Waking one op and dispatching it drops `rs_full` to 0 one edge later.
- Issue LW (5'b10100) and then SW.
  - No entry is allocated, `rs_full` stays 0, and no dispatch occurs.
- Fill 2 entries waiting on tag 5, assert `rst` for one cycle, then broadcast `alu_num`=5.
  - No dispatch ever occurs; all outputs hold their reset values.
